// File: rtl/image_pkg.sv
// Constants and types shared by the frame BRAM writer and reader paths.
package image_pkg;

    localparam int ADDR_WIDTH      = 18;
    localparam int PIXEL_WIDTH     = 24;
    localparam int IMG_W           = 512;
    localparam int IMG_H           = 512;
    localparam int NUM_PIXELS      = IMG_W * IMG_H;
    localparam int BYTES_PER_PIXEL = 3;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_RD,
        SEND,
        WAIT_ACK,
        WAIT_TX,
        FINISH
    } rd_state_t;

    // Byte 0 is the most significant byte (R), matching the writer's assembly order.
    function automatic logic [7:0] pixel_byte(input logic [PIXEL_WIDTH-1:0] pix,
                                              input logic [1:0]             idx);
        case (idx)
            2'd0:    pixel_byte = pix[23:16];
            2'd1:    pixel_byte = pix[15:8];
            default: pixel_byte = pix[7:0];
        endcase
    endfunction

endpackage

// File: rtl/pixel_serializer.sv
// Holds one captured pixel and hands it to tx_uart one byte at a time,
// reporting each finished byte and the end of the pixel to the address FSM.
module pixel_serializer
    import image_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [PIXEL_WIDTH-1:0] pix_in,
    input  logic                   in_send,
    input  logic                   in_wait_tx,
    input  logic                   tx_busy,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    output logic                   byte_done,
    output logic                   pixel_done
);

    logic [PIXEL_WIDTH-1:0] pix_q, pix_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   last_byte;

    assign last_byte = (byte_idx_q == 2'(BYTES_PER_PIXEL - 1));

    always_comb begin
        tx_start   = in_send && !tx_busy;
        byte_done  = in_wait_tx && !tx_busy;
        pixel_done = byte_done && last_byte;
    end

    // tx_data is updated on the same edge that enters SEND, so it is already
    // valid in the cycle tx_start is raised and stays put until the next byte.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        pix_d      = pix_q;
        byte_idx_d = byte_idx_q;
        tx_data_d  = tx_data_q;
        if (load) begin
            pix_d      = pix_in;
            byte_idx_d = 2'd0;
            tx_data_d  = pixel_byte(pix_in, 2'd0);
        end else if (byte_done && !last_byte) begin
            byte_idx_d = byte_idx_q + 2'd1;
            tx_data_d  = pixel_byte(pix_q, byte_idx_q + 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            pix_q      <= '0;
            byte_idx_q <= '0;
            tx_data_q  <= '0;
        end else begin
            pix_q      <= pix_d;
            byte_idx_q <= byte_idx_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_data = tx_data_q;

endmodule

// File: rtl/bram_uart_reader.sv
// Frame readback: walks the frame BRAM from address 0 upwards and streams each
// pixel to tx_uart as three bytes, R first, so a dump can be re-uploaded as-is.
module bram_uart_reader #(
    parameter int ADDR_WIDTH   = image_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH   = image_pkg::PIXEL_WIDTH,
    parameter int NUM_PIXELS   = image_pkg::NUM_PIXELS,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  en,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  busy,
    output logic                  done
);

    import image_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);
    localparam logic [1:0]            LAT_LAST  = 2'(READ_LATENCY - 1);

    rd_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            lat_cnt_q, lat_cnt_d;
    logic                  lat_expired;
    logic                  last_addr;
    logic                  load;
    logic                  in_send;
    logic                  in_wait_tx;
    logic                  byte_done;
    logic                  pixel_done;

    assign lat_expired = (lat_cnt_q == LAT_LAST);
    assign last_addr   = (addr_q == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = READ;
            READ:     state_d = WAIT_RD;
            WAIT_RD:  if (lat_expired) state_d = SEND;
            SEND:     if (!tx_busy) state_d = WAIT_ACK;
            WAIT_ACK: if (tx_busy) state_d = WAIT_TX;
            WAIT_TX: begin
                if (byte_done) begin
                    if (!pixel_done)    state_d = SEND;
                    else if (last_addr) state_d = FINISH;
                    else                state_d = READ;
                end
            end
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // The address only moves forward between pixels and never past LAST_ADDR;
    // it returns to 0 on the way out through FINISH.
    always_comb begin
        addr_d    = addr_q;
        lat_cnt_d = (state_q == WAIT_RD) ? lat_cnt_q + 2'd1 : 2'd0;
        case (state_q)
            IDLE:    if (start) addr_d = '0;
            WAIT_TX: if (pixel_done && !last_addr) addr_d = addr_q + 1'b1;
            FINISH:  addr_d = '0;
            default: addr_d = addr_q;
        endcase
    end

    always_comb begin
        en         = (state_q == READ);
        busy       = (state_q != IDLE);
        done       = (state_q == FINISH);
        load       = (state_q == WAIT_RD) && lat_expired;
        in_send    = (state_q == SEND);
        in_wait_tx = (state_q == WAIT_TX);
    end

    assign addr = addr_q;

    pixel_serializer u_serializer (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .pix_in     (dout),
        .in_send    (in_send),
        .in_wait_tx (in_wait_tx),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .byte_done  (byte_done),
        .pixel_done (pixel_done)
    );

endmodule

// File: tb/tb_bram_uart_reader.sv
// Bench for bram_uart_reader: BRAM and tx_uart models plus a byte-order
// reference built from the memory image.
module tb_bram_uart_reader;

    localparam int NP = 4;
    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        en;
    logic [17:0] addr;
    logic [23:0] dout;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    bram_uart_reader #(
        .ADDR_WIDTH   (18),
        .DATA_WIDTH   (24),
        .NUM_PIXELS   (NP),
        .READ_LATENCY (RL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .en       (en),
        .addr     (addr),
        .dout     (dout),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .busy     (busy),
        .done     (done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: data is presented only in the single cycle READ_LATENCY after en.
    logic [23:0] mem [NP];
    logic [23:0] p1 = '0, p2 = '0;
    bit          v1 = 1'b0, v2 = 1'b0;
    always @(posedge clk) begin
        v1 <= en;
        v2 <= v1;
        if (en) p1 <= mem[addr[1:0]];
        p2 <= p1;
    end
    assign dout = v2 ? p2 : 24'h5A5A5A;

    // tx_uart model: busy for tx_frame cycles after each tx_start, or forced high.
    int unsigned tx_frame  = 20;
    int unsigned busy_cnt  = 0;
    bit          busy_hold = 1'b0;
    always @(posedge clk) begin
        if (rst)           busy_cnt <= 0;
        else if (tx_start) busy_cnt <= tx_frame;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || busy_hold;

    // Monitor, sampled on the falling edge.
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] first_q[$];
    int         en_q[$];
    int         max_addr     = 0;
    int         done_cnt     = 0;
    int         ts_busy_viol = 0;
    int         ts_b2b_viol  = 0;
    int         first_ts     = -1;
    int         start_cyc    = 0;
    int         busy_low     = 0;
    bit         prev_ts      = 1'b0;

    always @(negedge clk) begin
        if (tx_start) begin
            got_q.push_back(tx_data);
            if (first_ts < 0) first_ts <= cyc - start_cyc;
            if (tx_busy) ts_busy_viol <= ts_busy_viol + 1;
            if (prev_ts) ts_b2b_viol <= ts_b2b_viol + 1;
        end
        prev_ts <= tx_start;
        if (en) en_q.push_back(int'(addr));
        if (int'(addr) > max_addr) max_addr <= int'(addr);
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic clear_mon();
        got_q.delete();
        en_q.delete();
        max_addr     = 0;
        done_cnt     = 0;
        ts_busy_viol = 0;
        ts_b2b_viol  = 0;
        first_ts     = -1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ":en"},       32'(en),       0);
        check({tag, ":addr"},     32'(addr),     0);
        check({tag, ":tx_data"},  32'(tx_data),  0);
        check({tag, ":tx_start"}, 32'(tx_start), 0);
        check({tag, ":busy"},     32'(busy),     0);
        check({tag, ":done"},     32'(done),     0);
    endtask

    // Reference: pixels in address order, each as R,G,B by plain shifting.
    task automatic build_expected();
        exp_q.delete();
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < 3; b++)
                exp_q.push_back(8'((mem[p] >> (16 - 8 * b)) & 24'hFF));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        busy_low = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            if (!busy) busy_low++;
        end
        check({tag, ":done_seen"}, 32'(seen), 1);
        check({tag, ":busy_held"}, 32'(busy_low), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (got_q.size() >= n) seen = 1'b1;
        end
        check({tag, ":bytes_reached"}, 32'(seen), 1);
    endtask

    task automatic compare_dump(input string tag);
        check({tag, ":byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s:byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, ":en_count"}, 32'(en_q.size()), NP);
        for (int i = 0; i < en_q.size() && i < NP; i++)
            check($sformatf("%s:en_addr%0d", tag, i), 32'(en_q[i]), 32'(i));
        check({tag, ":max_addr"},  32'(max_addr),     NP - 1);
        check({tag, ":done_cnt"},  32'(done_cnt),     1);
        check({tag, ":ts_busy"},   32'(ts_busy_viol), 0);
        check({tag, ":ts_b2b"},    32'(ts_b2b_viol),  0);
    endtask

    task automatic run_dump(input string tag);
        clear_mon();
        pulse_start();
        wait_done(tag, 3000);
        compare_dump(tag);
    endtask

    initial begin
        mem[0] = 24'h112233;
        mem[1] = 24'hAABBCC;
        mem[2] = 24'h000000;
        mem[3] = 24'hFFFFFF;
        build_expected();

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;

        // Basic dump, byte order, en addresses and first-byte latency.
        run_dump("dump1");
        check("dump1:first_tx_latency", 32'(first_ts), 1 + RL + 1);
        first_q = got_q;

        // Back-to-back dump: idle in between, identical output.
        check("between:addr", 32'(addr), 0);
        check("between:busy", 32'(busy), 0);
        run_dump("dump2");
        check("dump2:same_len", 32'(got_q.size()), 32'(first_q.size()));
        for (int i = 0; i < first_q.size() && i < got_q.size(); i++)
            check($sformatf("dump2:same%0d", i), 32'(got_q[i]), 32'(first_q[i]));

        // tx_busy held high when SEND is first reached.
        clear_mon();
        busy_hold = 1'b1;
        pulse_start();
        repeat (50) @(negedge clk);
        check("hold:no_tx_start", 32'(got_q.size()), 0);
        busy_hold = 1'b0;
        wait_done("hold", 3000);
        compare_dump("hold");

        // start re-pulsed mid-dump is ignored.
        clear_mon();
        pulse_start();
        wait_bytes("restart", 5, 1000);
        pulse_start();
        wait_done("restart", 3000);
        repeat (60) @(posedge clk);
        #1;
        compare_dump("restart");
        check("restart:idle_after", 32'(busy), 0);

        // Reset mid-dump aborts; a fresh dump starts from the first byte.
        clear_mon();
        pulse_start();
        wait_bytes("abort", 4, 1000);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("abort");
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("abort:no_more_bytes", 32'(got_q.size()), 4);
        check("abort:last_byte", 32'(got_q[3]), 32'h0000_00AA);
        run_dump("after_abort");

        // start during rst is ignored.
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("start_in_rst:busy", 32'(busy), 0);

        // Random images with random UART frame lengths.
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < NP; p++) mem[p] = 24'($urandom);
            tx_frame = $urandom_range(1, 25);
            build_expected();
            run_dump($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
